// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the RV32M/RV64M multiply/divide execute unit:
// funct3 codes, the M-extension funct7 and the FSM state encoding.
package ex_muldiv_pkg;

    localparam logic [2:0] INST_MUL    = 3'b000;
    localparam logic [2:0] INST_MULH   = 3'b001;
    localparam logic [2:0] INST_MULHSU = 3'b010;
    localparam logic [2:0] INST_MULHU  = 3'b011;
    localparam logic [2:0] INST_DIV    = 3'b100;
    localparam logic [2:0] INST_DIVU   = 3'b101;
    localparam logic [2:0] INST_REM    = 3'b110;
    localparam logic [2:0] INST_REMU   = 3'b111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/ex_muldiv_sign.sv
// Operand sign handling for mul/div: magnitudes, result sign flag and the
// divide-by-zero / signed-overflow shortcut with its architectural result.
module ex_muldiv_sign
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic [XLEN-1:0] mag1_o,
    output logic [XLEN-1:0] mag2_o,
    output logic            neg_o,
    output logic            fast_o,
    output logic [XLEN-1:0] fast_res_o
);

    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    logic is_div;
    logic is_rem;
    logic sgn1;
    logic sgn2;
    logic neg1;
    logic neg2;
    logic div0;
    logic ovf;

    always_comb begin
        is_div = op_i[2];
        is_rem = op_i[2] & op_i[1];
        sgn1   = (op_i == INST_MULH) || (op_i == INST_MULHSU)
              || (op_i == INST_DIV)  || (op_i == INST_REM);
        sgn2   = (op_i == INST_MULH) || (op_i == INST_DIV)
              || (op_i == INST_REM);
        neg1   = sgn1 & rs1_i[XLEN-1];
        neg2   = sgn2 & rs2_i[XLEN-1];
        mag1_o = neg1 ? -rs1_i : rs1_i;
        mag2_o = neg2 ? -rs2_i : rs2_i;
        // Remainder follows the dividend; product/quotient follow the xor.
        neg_o  = is_rem ? neg1 : (neg1 ^ neg2);
        div0   = is_div && (rs2_i == '0);
        ovf    = is_div && sgn2 && (rs1_i == SMIN) && (rs2_i == '1);
        fast_o = div0 | ovf;
        if (div0) begin
            fast_res_o = is_rem ? rs1_i : '1;
        end else begin
            fast_res_o = is_rem ? '0 : rs1_i;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative M-extension execute unit: one bit per cycle shift-add multiply
// and restoring divide, with stall request and flush abort.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      reg_w_addr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            hold_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            reg_w_ena_o,
    output logic [4:0]      reg_w_addr_o
);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   opd_q, opd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   res_q, res_d;

    logic [XLEN-1:0]   mag1;
    logic [XLEN-1:0]   mag2;
    logic              sgn_neg;
    logic              fast;
    logic [XLEN-1:0]   fast_res;

    logic [XLEN-1:0]   mcand;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_rem;
    logic [XLEN:0]     div_try;
    logic [2*XLEN-1:0] iter;

    ex_muldiv_sign #(
        .XLEN (XLEN)
    ) u_sign (
        .op_i       (op_i),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .mag1_o     (mag1),
        .mag2_o     (mag2),
        .neg_o      (sgn_neg),
        .fast_o     (fast),
        .fast_res_o (fast_res)
    );

    function automatic logic [XLEN-1:0] finish(
        input logic [2:0]        op,
        input logic              neg,
        input logic [2*XLEN-1:0] acc
    );
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   part;
        prod = neg ? -acc : acc;
        if (!op[2]) begin
            return (op == INST_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
        part = op[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        return neg ? -part : part;
    endfunction

    // acc holds {product hi, multiplier} or {remainder, quotient}.
    always_comb begin
        mcand   = acc_q[0] ? opd_q : '0;
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mcand};
        div_rem = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_try = div_rem - {1'b0, opd_q};
        if (!op_q[2]) begin
            iter = {mul_sum, acc_q[XLEN-1:1]};
        end else if (div_try[XLEN]) begin
            iter = {div_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            iter = {div_try[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        rd_d    = rd_q;
        opd_d   = opd_q;
        acc_d   = acc_q;
        res_d   = res_q;
        unique case (state_q)
            MD_IDLE: begin
                if (!flush_i && start_i) begin
                    op_d  = op_i;
                    neg_d = sgn_neg;
                    rd_d  = reg_w_addr_i;
                    opd_d = mag2;
                    acc_d = {{XLEN{1'b0}}, mag1};
                    if (fast) begin
                        res_d   = fast_res;
                        state_d = MD_DONE;
                    end else begin
                        cnt_d   = CNT_W'(XLEN);
                        state_d = MD_CALC;
                    end
                end
            end
            MD_CALC: begin
                if (flush_i) begin
                    cnt_d   = '0;
                    state_d = MD_IDLE;
                end else begin
                    acc_d = iter;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        res_d   = finish(op_q, neg_q, iter);
                        state_d = MD_DONE;
                    end
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            rd_q    <= '0;
            opd_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            rd_q    <= rd_d;
            opd_q   <= opd_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    assign busy_o       = (state_q == MD_CALC);
    assign hold_o       = (start_i && (state_q == MD_IDLE) && !fast) || busy_o;
    assign valid_o      = (state_q == MD_DONE) && !flush_i;
    assign reg_w_ena_o  = valid_o;
    assign result_o     = res_q;
    assign reg_w_addr_o = rd_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed and random ops against a
// plain-arithmetic reference, with flush, reset and held-start scenarios.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start_i = 1'b0;
    logic            flush_i = 1'b0;
    logic [2:0]      op_i = '0;
    logic [XLEN-1:0] rs1_i = '0;
    logic [XLEN-1:0] rs2_i = '0;
    logic [4:0]      reg_w_addr_i = '0;
    logic            busy_o;
    logic            hold_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;
    logic            reg_w_ena_o;
    logic [4:0]      reg_w_addr_o;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [XLEN-1:0] res;
        logic [4:0]      rd;
        int              cyc;
    } exp_t;

    exp_t sb_q[$];

    ex_muldiv #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .op_i         (op_i),
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .reg_w_addr_i (reg_w_addr_i),
        .flush_i      (flush_i),
        .busy_o       (busy_o),
        .hold_o       (hold_o),
        .valid_o      (valid_o),
        .result_o     (result_o),
        .reg_w_ena_o  (reg_w_ena_o),
        .reg_w_addr_o (reg_w_addr_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_fn(input logic [2:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        longint          sa = longint'(signed'(a));
        longint          sb = longint'(signed'(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        logic [63:0]     p;
        case (op)
            INST_MUL:    begin p = ua * ub; return p[31:0]; end
            INST_MULH:   begin p = sa * sb; return p[63:32]; end
            INST_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            INST_MULHU:  begin p = ua * ub; return p[63:32]; end
            INST_DIV:    return (b == 0) ? '1 : 32'(sa / sb);
            INST_DIVU:   return (b == 0) ? '1 : 32'(ua / ub);
            INST_REM:    return (b == 0) ? a : 32'(sa % sb);
            default:     return (b == 0) ? a : 32'(ua % ub);
        endcase
    endfunction

    function automatic logic [XLEN-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return '1;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Monitor: every presented result must match the oldest expectation.
    always @(negedge clk) begin
        #3;
        if (!rst) begin
            chk("ena_eq_valid", 64'(reg_w_ena_o), 64'(valid_o));
            if (valid_o) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_valid", 64'(valid_o), 64'(0));
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("result", 64'(result_o), 64'(e.res));
                    chk("rd", 64'(reg_w_addr_o), 64'(e.rd));
                    chk("valid_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    // Called on a falling edge; returns on a falling edge after valid_o.
    task automatic do_op(input logic [2:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [4:0] rd,
                         input logic [XLEN-1:0] exp, input bit keep);
        bit fast;
        bit done;
        exp_t e;
        fast = op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000
                                   && b == 32'hFFFF_FFFF));
        e.res = exp;
        e.rd  = rd;
        e.cyc = cyc + (fast ? 1 : XLEN + 1);
        sb_q.push_back(e);
        op_i = op;
        rs1_i = a;
        rs2_i = b;
        reg_w_addr_i = rd;
        start_i = 1'b1;
        done = 1'b0;
        for (int k = 0; k < XLEN + 8 && !done; k++) begin
            #1;
            chk("hold", 64'(hold_o), 64'(!fast && k <= XLEN));
            chk("busy", 64'(busy_o), 64'(!fast && k >= 1 && k <= XLEN));
            done = valid_o;
            @(negedge clk);
            if (keep && !done) begin
                op_i = 3'($urandom);
                rs1_i = 32'($urandom);
                rs2_i = 32'($urandom);
                reg_w_addr_i = 5'($urandom);
            end else begin
                start_i = 1'b0;
            end
        end
        start_i = 1'b0;
        if (!done) begin
            chk("valid_timeout", 64'(valid_o), 64'(1));
            sb_q.delete();
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy_o), 64'(0));
        chk({tag, "_hold"}, 64'(hold_o), 64'(0));
        chk({tag, "_valid"}, 64'(valid_o), 64'(0));
        chk({tag, "_ena"}, 64'(reg_w_ena_o), 64'(0));
        chk({tag, "_result"}, 64'(result_o), 64'(0));
        chk({tag, "_rd"}, 64'(reg_w_addr_o), 64'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;

        repeat (3) @(negedge clk);
        #1;
        chk_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_op(INST_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,
              32'hFFFF_FFEB, 1'b0);
        do_op(INST_MULH,   32'h8000_0000, 32'h8000_0000, 5'd6,
              32'h4000_0000, 1'b0);
        do_op(INST_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,
              32'hFFFF_FFFE, 1'b0);
        do_op(INST_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd8,
              32'hFFFF_FFFF, 1'b0);
        do_op(INST_DIV,    32'hFFFF_FFF9, 32'd2,         5'd9,
              32'hFFFF_FFFD, 1'b0);
        do_op(INST_REM,    32'hFFFF_FFF9, 32'd2,         5'd10,
              32'hFFFF_FFFF, 1'b0);
        do_op(INST_DIVU,   32'd100,       32'd7,         5'd11,
              32'd14, 1'b0);
        do_op(INST_REMU,   32'd100,       32'd7,         5'd12,
              32'd2, 1'b0);
        do_op(INST_DIVU,   32'd5,         32'd0,         5'd13,
              32'hFFFF_FFFF, 1'b0);
        do_op(INST_REM,    32'd5,         32'd0,         5'd14,
              32'd5, 1'b0);
        do_op(INST_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd15,
              32'h8000_0000, 1'b0);
        do_op(INST_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd16,
              32'd0, 1'b0);

        // Start held with changing operands: only the first op counts.
        do_op(INST_MULH, 32'h1234_5678, 32'hFEDC_BA98, 5'd17,
              ref_fn(INST_MULH, 32'h1234_5678, 32'hFEDC_BA98), 1'b1);

        // Flush in cycle 10 of a divide, then a multiply at cycle 12.
        op_i = INST_DIV;
        rs1_i = 32'd1000;
        rs2_i = 32'd3;
        reg_w_addr_i = 5'd20;
        start_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        flush_i = 1'b1;
        #1;
        chk("flush_valid", 64'(valid_o), 64'(0));
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        chk("flush_idle_busy", 64'(busy_o), 64'(0));
        @(negedge clk);
        do_op(INST_MUL, 32'd3, 32'd4, 5'd21, 32'd12, 1'b0);

        // Reset in the middle of a calculation.
        op_i = INST_DIVU;
        rs1_i = 32'hDEAD_BEEF;
        rs2_i = 32'd3;
        reg_w_addr_i = 5'd22;
        start_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk_zero_outputs("midreset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 60; n++) begin
            op = 3'($urandom);
            a = pick();
            b = pick();
            do_op(op, a, b, 5'($urandom), ref_fn(op, a, b),
                  ($urandom_range(0, 4) == 0));
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
